manch_clk_recovery: RTL and testbench

Parametrised Manchester receiver front end: it measures the half-bit period, recovers a 50 %-duty bit clock aligned to the mid-bit transitions, and decodes the NRZ data with a per-bit strobe and a lock/error status. It sits between the raw Manchester line input and the frame/byte deserialiser. It replaces the fixed-width, data-less sync clock generator and adds these functions:

- glitch rejection
- lock qualification
- mid-bit phase hunting
- decoded data output

---
 rtl/manch_clk_recovery.sv | 230 +++++++++++++++++++++++
 tb/tb_manch_clk_recovery.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/manch_clk_recovery.sv
// Manchester receiver front end: half-bit period measurement, lock qualification,
// mid-bit clock recovery and NRZ decode. Define MANCH_THOMAS_POL_EN for G.E. Thomas polarity.
module manch_clk_recovery #(
   parameter int unsigned CNT_W        = 32,
   parameter int unsigned WINDOW       = 200000,
   parameter int unsigned HALF_INIT    = 25000,
   parameter int unsigned MIN_HALF     = 4,
   parameter int unsigned LOCK_WINDOWS = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             man_in,
   output logic             sync_clk,
   output logic             data_bit,
   output logic             data_valid,
   output logic             locked,
   output logic             err,
   output logic [CNT_W-1:0] half_bit
);

   localparam int unsigned      TW        = CNT_W + 2;
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(WINDOW - 1);
   localparam logic [CNT_W-1:0] MIN_RUN   = CNT_W'(MIN_HALF);
   localparam logic [CNT_W-1:0] LOCK_MAX  = CNT_W'(LOCK_WINDOWS);
   localparam logic [CNT_W-1:0] HALF_RST  = CNT_W'(HALF_INIT);

   localparam logic [0:0] ST_HUNT  = 1'b0;
   localparam logic [0:0] ST_TRACK = 1'b1;

   logic             d1;
   logic             d2;
   logic             edge_det;
   logic             valid_edge;
   logic [CNT_W-1:0] run_cnt;
   logic [CNT_W-1:0] run_len;

   logic [CNT_W-1:0] win_cnt;
   logic [CNT_W-1:0] win_min;
   logic [CNT_W-1:0] new_min;
   logic             win_seen;
   logic             seen_now;
   logic             wrap;

   logic [TW-1:0]    half_x;
   logic [TW-1:0]    min_x;
   logic [TW-1:0]    min_diff;
   logic             consistent;
   logic [CNT_W-1:0] lock_cnt;
   logic [CNT_W-1:0] lock_nxt;
   logic             lock_drop;
   logic             lock_ok;

   logic [TW-1:0]    t15;
   logic [TW-1:0]    t25;
   logic [TW-1:0]    run_x;
   logic [TW-1:0]    timer_x;
   logic [CNT_W-1:0] timer;
   logic [0:0]       state;
   logic             dec_bit;
   logic             hunt_hit;
   logic             track_hit;

   // ---------------------------------------------------------------------------
   // Input synchroniser, edge detect and run-length counter
   // ---------------------------------------------------------------------------
   // NOTE: every sequential block uses non-blocking assignments so all registers
   // sample the same pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d1 <= 1'b0;
         d2 <= 1'b0;
      end else begin
         d1 <= man_in;
         d2 <= d1;
      end
   end

   assign edge_det   = d1 ^ d2;
   assign run_len    = run_cnt;
   assign valid_edge = edge_det && (run_len >= MIN_RUN);

   // Invalid (glitch) edges still restart the run so the glitch never merges into a run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_cnt <= '0;
      end else if (edge_det) begin
         run_cnt <= CNT_ONE;
      end else if (run_cnt != CNT_MAX) begin
         run_cnt <= run_cnt + CNT_ONE;
      end
   end

   // ---------------------------------------------------------------------------
   // Measurement window: shortest valid run per window becomes the half-bit period
   // ---------------------------------------------------------------------------
   assign wrap     = (win_cnt == WIN_LAST);
   assign new_min  = (valid_edge && (run_len < win_min)) ? run_len : win_min;
   assign seen_now = win_seen | valid_edge;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_cnt  <= '0;
         win_min  <= CNT_MAX;
         win_seen <= 1'b0;
         half_bit <= HALF_RST;
      end else if (wrap) begin
         win_cnt  <= '0;
         win_min  <= CNT_MAX;
         win_seen <= 1'b0;
         if (new_min != CNT_MAX)
            half_bit <= new_min;
      end else begin
         win_cnt  <= win_cnt + CNT_ONE;
         win_min  <= new_min;
         win_seen <= seen_now;
      end
   end

   // ---------------------------------------------------------------------------
   // Lock qualification against the pre-update estimate (tolerance half_bit/8)
   // ---------------------------------------------------------------------------
   assign half_x     = {2'b00, half_bit};
   assign min_x      = {2'b00, new_min};
   assign min_diff   = (min_x >= half_x) ? (min_x - half_x) : (half_x - min_x);
   assign consistent = seen_now && (min_diff <= (half_x >> 3));

   // NOTE: the default assignment first keeps this block purely combinational.
   always_comb begin
      lock_nxt = lock_cnt;
      if (wrap) begin
         if (!consistent)
            lock_nxt = '0;
         else if (lock_cnt != LOCK_MAX)
            lock_nxt = lock_cnt + CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_cnt <= '0;
         locked   <= 1'b0;
      end else begin
         lock_cnt <= lock_nxt;
         locked   <= (lock_nxt == LOCK_MAX);
      end
   end

   // A lock loss in this very cycle overrides any mid-bit edge seen alongside it.
   assign lock_drop = wrap && !consistent;
   assign lock_ok   = locked && !lock_drop;

   // ---------------------------------------------------------------------------
   // Thresholds, evaluated from the current (pre-wrap) half_bit
   // ---------------------------------------------------------------------------
   assign t15     = half_x + (half_x >> 1);
   assign t25     = (half_x << 1) + (half_x >> 1);
   assign run_x   = {2'b00, run_len};
   assign timer_x = {2'b00, timer};

`ifdef MANCH_THOMAS_POL_EN
   assign dec_bit = ~d1;
`else
   assign dec_bit = d1;
`endif

   // Only a run spanning two half-bits guarantees the edge ending it is mid-bit.
   assign hunt_hit  = lock_ok && valid_edge && (run_x >= t15);
   assign track_hit = valid_edge && (timer_x >= t15);

   // ---------------------------------------------------------------------------
   // Decoder FSM and recovered clock
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_HUNT;
         timer      <= '0;
         sync_clk   <= 1'b0;
         data_bit   <= 1'b0;
         data_valid <= 1'b0;
         err        <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         err        <= 1'b0;
         case (state)
            ST_HUNT: begin
               timer    <= '0;
               sync_clk <= 1'b0;
               if (hunt_hit) begin
                  state      <= ST_TRACK;
                  timer      <= CNT_ONE;
                  sync_clk   <= 1'b1;
                  data_valid <= 1'b1;
                  data_bit   <= dec_bit;
               end
            end
            ST_TRACK: begin
               if (!lock_ok) begin
                  state    <= ST_HUNT;
                  timer    <= '0;
                  sync_clk <= 1'b0;
               end else if (track_hit) begin
                  timer      <= CNT_ONE;
                  sync_clk   <= 1'b1;
                  data_valid <= 1'b1;
                  data_bit   <= dec_bit;
               end else if (timer_x >= t25) begin
                  state    <= ST_HUNT;
                  timer    <= '0;
                  sync_clk <= 1'b0;
                  err      <= 1'b1;
               end else begin
                  if (timer != CNT_MAX)
                     timer <= timer + CNT_ONE;
                  // Greater-or-equal also covers a half_bit that shrank mid-bit.
                  if (timer >= half_bit)
                     sync_clk <= 1'b0;
               end
            end
            default: begin
               state    <= ST_HUNT;
               timer    <= '0;
               sync_clk <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_manch_clk_recovery.sv
// Directed bench for manch_clk_recovery: reset, lock, decode, glitch, tracking loss,
// relock and asynchronous reset; expected bits follow MANCH_THOMAS_POL_EN.
module tb_manch_clk_recovery;

   localparam int CNT_W = 32;
   localparam int HB    = 100;
`ifdef MANCH_THOMAS_POL_EN
   localparam bit POL = 1'b1;
`else
   localparam bit POL = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             man_in = 1'b0;
   logic             sync_clk;
   logic             data_bit;
   logic             data_valid;
   logic             locked;
   logic             err;
   logic [CNT_W-1:0] half_bit;

   manch_clk_recovery #(
      .CNT_W(CNT_W), .WINDOW(2000), .HALF_INIT(250), .MIN_HALF(4), .LOCK_WINDOWS(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .man_in(man_in), .sync_clk(sync_clk),
      .data_bit(data_bit), .data_valid(data_valid), .locked(locked),
      .err(err), .half_bit(half_bit)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   always @(posedge clk) if (rst_n) cyc <= cyc + 1;

   // Observation records, sampled on the falling edge
   bit dv_bit[$];
   int dv_cyc[$];
   int dv_unlocked = 0;
   int hi_cnt = 0, pulses = 0, sync_bad = 0;
   int err_cnt = 0, err_gap = 0, last_dv = 0;
   logic err_sync = 1'b1;
   logic [CNT_W-1:0] hb_w1, hb_w5;
   logic lk_w2, lk_w3, lk_w5, lk_w6, lk_w8;

   always @(negedge clk) begin
      if (rst_n) begin
         if (data_valid) begin
            dv_bit.push_back(data_bit);
            dv_cyc.push_back(cyc);
            last_dv = cyc;
            if (!locked) dv_unlocked++;
         end
         if (sync_clk) hi_cnt++;
         else if (hi_cnt != 0) begin
            pulses++;
            if (hi_cnt != HB) sync_bad++;
            hi_cnt = 0;
         end
         if (err) begin
            err_cnt++;
            err_gap  = cyc - last_dv;
            err_sync = sync_clk;
         end
         case (cyc)
            2100:  hb_w1 = half_bit;
            4100:  lk_w2 = locked;
            6100:  lk_w3 = locked;
            10100: begin hb_w5 = half_bit; lk_w5 = locked; end
            12100: lk_w6 = locked;
            16100: lk_w8 = locked;
            default: ;
         endcase
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic line(input logic lvl, input int n);
      man_in = lvl;
      repeat (n) @(negedge clk);
   endtask

   // IEEE 802.3 line coding, MSB first; gi selects a bit whose second half carries
   // a 2-cycle pulse starting 2 cycles after its mid-bit edge (-1 for none).
   task automatic send_byte(input logic [7:0] b, input int gi);
      for (int i = 7; i >= 0; i--) begin
         line(~b[i], HB);
         if (i == gi) begin
            line(b[i], 2);
            line(~b[i], 2);
            line(b[i], HB - 4);
         end else begin
            line(b[i], HB);
         end
      end
   endtask

   task automatic check_byte(input string tag, input int s, input logic [7:0] b);
      check({tag, "_count"}, dv_bit.size() - s, 8);
      for (int k = 0; k < 8 && (s + k) < dv_bit.size(); k++) begin
         check($sformatf("%s_bit%0d", tag, k), dv_bit[s + k], b[7 - k] ^ POL);
         if (k > 0) begin
            int d;
            d = dv_cyc[s + k] - dv_cyc[s + k - 1];
            check($sformatf("%s_gap%0d", tag, k), (d >= 199 && d <= 201), 1);
         end
      end
   endtask

   initial begin
      int s;
      int k;

      // Reset with the line toggling
      for (int i = 0; i < 20; i++) begin
         man_in = ~man_in;
         @(negedge clk);
      end
      check("rst_sync_clk", sync_clk, 0);
      check("rst_data_bit", data_bit, 0);
      check("rst_data_valid", data_valid, 0);
      check("rst_locked", locked, 0);
      check("rst_err", err, 0);
      check("rst_half_bit", half_bit, 250);
      man_in = 1'b0;
      rst_n  = 1'b1;

      // Lock acquisition: first window adopts 100 but is inconsistent with 250
      line(0, 300);
      send_byte(8'h55, -1);
      send_byte(8'h00, -1);
      send_byte(8'h55, -1);
      send_byte(8'h00, -1);
      check("half_bit_after_wrap1", hb_w1, 100);
      check("locked_after_wrap2", lk_w2, 0);
      check("locked_after_wrap3", lk_w3, 1);
      check("no_dv_before_lock", dv_bit.size(), 0);

      // Decode
      s = dv_bit.size();
      send_byte(8'hA5, -1);
      check_byte("decode_a5", s, 8'hA5);

      // Glitch rejection
      s = dv_bit.size();
      send_byte(8'h0F, 4);
      check_byte("glitch_0f", s, 8'h0F);

      // Tracking loss: static line through a whole window
      line(1, 2400);
      check("half_bit_after_glitch", hb_w5, 100);
      check("locked_after_glitch", lk_w5, 1);
      check("err_count", err_cnt, 1);
      check("err_timer", err_gap, 250);
      check("err_sync_clk", err_sync, 0);
      check("locked_after_idle_window", lk_w6, 0);
      check("sync_high_time", sync_bad, 0);
      check("sync_pulses", pulses, dv_bit.size());

      // Relock and decode again
      send_byte(8'h00, -1);
      send_byte(8'h55, -1);
      send_byte(8'h00, -1);
      send_byte(8'h55, -1);
      check("relocked", lk_w8, 1);
      s = dv_bit.size();
      send_byte(8'hA5, -1);
      check_byte("redecode_a5", s, 8'hA5);
      check("half_bit_end", half_bit, 100);

      // Reset in the middle of a data_valid pulse
      line(1, HB);
      man_in = 1'b0;
      k = 0;
      @(posedge clk);
      #1;
      while (!data_valid && k < 10) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("dv_before_reset", data_valid, 1);
      rst_n = 1'b0;
      #1;
      check("midrst_data_valid", data_valid, 0);
      check("midrst_sync_clk", sync_clk, 0);
      check("midrst_locked", locked, 0);
      check("midrst_half_bit", half_bit, 250);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      s = dv_bit.size();
      line(1, 150);
      line(0, 250);
      check("no_dv_after_reset", dv_bit.size() - s, 0);
      check("dv_only_when_locked", dv_unlocked, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
